mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Request/response front end that sits directly upstream of the single-port `memory` block and drives its wr/rd/addr/bidirectional data pins.
- Converts a valid/ready request stream (read or write) into correctly timed memory cycles.
- Owns the tri-state data bus and returns read data as a one-cycle response pulse.

Parameters:
AWIDTH, 5, address width; must match the attached memory
DWIDTH, 8, data width; must match the attached memory

Ports:
clk  input  1  single clock; all state changes on posedge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_wr  input  1  1 = write, 0 = read; sampled with req_valid&&req_ready
req_addr  input  AWIDTH  request address
req_wdata  input  DWIDTH  write data
rsp_valid  output  1  one-cycle pulse: rsp_rdata valid
rsp_rdata  output  DWIDTH  read data
mem_wr  output  1  to memory wr
mem_rd  output  1  to memory rd
mem_addr  output  AWIDTH  to memory addr
mem_data  inout  DWIDTH  to memory data; driven only during write
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE; mem_wr=0, mem_rd=0, mem_addr=0, mem_data=all-Z.
  - rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1 once reset is released.
- rst asserted mid-operation: the in-flight request is dropped with no rsp_valid, the bus is released in the same delta, and no memory cycle completes.
- All memory-side outputs are registered. No combinational path from req_* to mem_*.
- req_ready = (state==IDLE) && !rst. A request is accepted on a posedge with req_valid&&req_ready; addr, wr and wdata are latched at that edge.
- FSM:
  - IDLE: on accept, go to WRITE if req_wr=1, else RD_ADDR.
  - WRITE: mem_wr=1, mem_rd=0, mem_addr=latched addr, mem_data driven with latched wdata. Lasts 1 cycle, then IDLE.
  - RD_ADDR: mem_rd=1, mem_wr=0, mem_addr=latched addr, mem_data=Z. Lasts 1 cycle, then RD_DATA.
  - RD_DATA: mem_rd=1 and mem_addr held. At the closing posedge, mem_data is captured into rsp_rdata and rsp_valid is set. Then IDLE.
- rsp_valid is high for exactly the one cycle after RD_DATA (first IDLE cycle). There is no response backpressure. rsp_rdata holds its value until the next read.
- Latency, accept edge to memory strobe: 1 cycle.
- Read latency, accept edge to rsp_valid high: 3 cycles.
- Throughput: writes take 2 cycles per request, reads 3.
- A new request may be accepted in the same cycle rsp_valid is high.
- mem_wr and mem_rd are never both 1.
- mem_data is never driven while mem_rd=1. The driver turns on/off only at state-register edges.
- Addresses wrap naturally within AWIDTH; all-ones and zero addresses need no special handling.
- req_valid deasserted while not ready: no effect. Request fields may change freely while req_ready=0.

Optional Feature:
- Macro: MEM_CTRL_WRCHK_EN
- With the macro defined:
  - Adds output wrchk_err (1 bit, reset 0).
  - Every WRITE is followed by WRCHK_A (rd=1, same addr) and then WRCHK_D (rd=1).
  - At the end of WRCHK_D, mem_data is compared with the latched wdata. On mismatch, wrchk_err is set sticky until rst.
  - Writes then take 4 cycles, and busy stays high through both check states.
  - rsp_valid is not pulsed for check reads.
- Without the macro: no wrchk_err port and no check states; write timing is as above.

Test Plan:
- Reset: hold rst 2 cycles mid-read → mem_rd=0 immediately, mem_data=Z, no rsp_valid, req_ready=1 after release.
- Write addr=5'b00000 data=8'hFF, then addr=5'b11111 data=8'h00. Read both back → rsp_rdata 8'hFF then 8'h00, each 3 cycles after accept.
- Sweep: write ascending data 0..30 to descending addresses 31..1, then read back → every rsp_rdata matches, no pulse missing or extra.
- Back-to-back: req_valid held high with alternating write/read to addr 5'b01010 data 8'hA5 → req_ready pattern 1,0,1,0,0,1; read returns 8'hA5; mem_wr and mem_rd never overlap.
- Bus contention check: monitor mem_data for X during every RD_ADDR/RD_DATA cycle → no X on any bit; Z from controller outside WRITE.
- With MEM_CTRL_WRCHK_EN: force the memory model to corrupt a write to addr 3 (8'h3C stored as 8'h3D) → wrchk_err rises at the end of WRCHK_D and stays high until rst; a clean write keeps it 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: turns a valid/ready read/write request stream into timed cycles on a single-port memory (wr/rd/addr/tri-state data).
// Latency: memory strobe 1 cycle after accept; read response pulse 3 cycles after accept; writes 2 cycles/request, reads 3.
// Backpressure: req_ready only in IDLE; rsp_valid is an unthrottled one-cycle pulse. MEM_CTRL_WRCHK_EN adds a write read-back check (wrchk_err).
module mem_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data,
`ifdef MEM_CTRL_WRCHK_EN
    output logic              wrchk_err,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WRCHK_A,
        ST_WRCHK_D
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              mem_wr_nxt;
    logic              mem_rd_nxt;
    logic              drv_en;
    logic [DWIDTH-1:0] wdata_q;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;

    // The bus driver is a flop, so it only switches at state-register edges and drops asynchronously on reset.
    assign mem_data = drv_en ? wdata_q : {DWIDTH{1'bz}};

    // Next-state and next memory strobes; strobes are derived from the next state so the pins themselves are flops.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = req_wr ? ST_WRITE : ST_RD_ADDR;
                end
            end
`ifdef MEM_CTRL_WRCHK_EN
            ST_WRITE:   state_nxt = ST_WRCHK_A;
`else
            ST_WRITE:   state_nxt = ST_IDLE;
`endif
            ST_RD_ADDR: state_nxt = ST_RD_DATA;
            ST_RD_DATA: state_nxt = ST_IDLE;
            ST_WRCHK_A: state_nxt = ST_WRCHK_D;
            ST_WRCHK_D: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        mem_wr_nxt = (state_nxt == ST_WRITE);
        mem_rd_nxt = (state_nxt == ST_RD_ADDR) || (state_nxt == ST_RD_DATA) ||
                     (state_nxt == ST_WRCHK_A) || (state_nxt == ST_WRCHK_D);
    end

    // State register, registered memory pins and the request latch (address doubles as mem_addr).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            drv_en   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state  <= state_nxt;
            mem_wr <= mem_wr_nxt;
            mem_rd <= mem_rd_nxt;
            drv_en <= mem_wr_nxt;
            if (accept) begin
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Capture read data at the closing edge of RD_DATA; the pulse lands in the first IDLE cycle and data holds until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == ST_RD_DATA);
            if (state == ST_RD_DATA) begin
                rsp_rdata <= mem_data;
            end
        end
    end

`ifdef MEM_CTRL_WRCHK_EN
    // Sticky flag: read-back at the end of WRCHK_D disagrees with the data just written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrchk_err <= 1'b0;
        end else if ((state == ST_WRCHK_D) && (mem_data != wdata_q)) begin
            wrchk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: random and directed request traffic against mem_ctrl with a behavioural memory and reference model.
// Latency: expectations are scheduled in whole cycles from the accept edge.
// Backpressure: requests are held until req_ready; responses are checked as unthrottled pulses.
module tb_mem_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef MEM_CTRL_WRCHK_EN
    localparam int WR_LEN = 3;
`else
    localparam int WR_LEN = 1;
`endif
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          busy;
`ifdef MEM_CTRL_WRCHK_EN
    logic          wrchk_err;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // behavioural memory plus a bus probe that drives the data pins whenever neither strobe is active
    logic [DW-1:0] mem_arr [32];
    logic [DW-1:0] probe_val = 8'h00;
    assign mem_data = mem_rd ? mem_arr[mem_addr] : {DW{1'bz}};
    assign mem_data = (!mem_rd && !mem_wr) ? probe_val : {DW{1'bz}};

    // reference model state
    logic [DW-1:0] shadow [32];
    logic [DW-1:0] exp_data [$];
    int            exp_due  [$];
    logic [DW-1:0] last_rsp = '0;
    int            op_start = 0;
    int            op_end   = -1;
    logic          op_wr    = 1'b0;
    logic [AW-1:0] op_addr  = '0;
    logic [DW-1:0] op_wdata = '0;
    int            err_at   = NEVER;

    mem_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
`ifdef MEM_CTRL_WRCHK_EN
        .wrchk_err (wrchk_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        probe_val <= 8'($urandom);
    end

    // memory write port; with the check feature the model corrupts 8'h3C written to address 3
    always @(posedge clk) begin
        if (mem_wr) begin
`ifdef MEM_CTRL_WRCHK_EN
            if (mem_addr == 5'd3 && mem_data == 8'h3C) mem_arr[mem_addr] <= 8'h3D;
            else                                       mem_arr[mem_addr] <= mem_data;
`else
            mem_arr[mem_addr] <= mem_data;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // called at the negedge preceding the accepting posedge (edge cyc+1)
    task automatic note_accept(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_start = cyc + 1;
        op_end   = cyc + (wr ? WR_LEN : 2);
        op_wr    = wr;
        op_addr  = a;
        op_wdata = d;
        if (wr) begin
`ifdef MEM_CTRL_WRCHK_EN
            if (a == 5'd3 && d == 8'h3C) begin
                shadow[a] = 8'h3D;
                if (err_at == NEVER) err_at = op_end + 1;
            end else begin
                shadow[a] = d;
            end
`else
            shadow[a] = d;
`endif
        end else begin
            exp_data.push_back(shadow[a]);
            exp_due.push_back(cyc + 3);
        end
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        else            note_accept(wr, a, d);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // per-cycle protocol monitor against the scheduled model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_bus_released", mem_data, probe_val);
`ifdef MEM_CTRL_WRCHK_EN
            chk("rst_wrchk_err", wrchk_err, 0);
            err_at = NEVER;
`endif
            exp_data.delete();
            exp_due.delete();
            last_rsp = '0;
            op_end   = -1;
        end else begin
            automatic logic in_op  = (cyc >= op_start) && (cyc <= op_end);
            automatic logic exp_wr = in_op && op_wr && (cyc == op_start);
            automatic logic exp_rd = in_op && !exp_wr;
            chk("busy", busy, in_op);
            chk("req_ready", req_ready, !in_op);
            chk("mem_wr", mem_wr, exp_wr);
            chk("mem_rd", mem_rd, exp_rd);
            if (mem_wr && mem_rd) chk("strobe_overlap", 1, 0);
            if (in_op) chk("mem_addr", mem_addr, op_addr);
            if (mem_rd) chk("bus_x_during_read", $isunknown(mem_data), 0);
            if (mem_wr) chk("bus_write_data", mem_data, op_wdata);
            if (!mem_rd && !mem_wr) chk("bus_released", mem_data, probe_val);
`ifdef MEM_CTRL_WRCHK_EN
            chk("wrchk_err", wrchk_err, cyc >= err_at);
`endif
            if (rsp_valid) begin
                if (exp_data.size() == 0) begin
                    chk("rsp_extra", 1, 0);
                end else begin
                    last_rsp = exp_data.pop_front();
                    chk("rsp_rdata", rsp_rdata, last_rsp);
                    chk("rsp_latency", cyc, exp_due.pop_front());
                end
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, last_rsp);
                if (exp_due.size() != 0 && exp_due[0] < cyc) begin
                    chk("rsp_missing", 0, 1);
                    void'(exp_data.pop_front());
                    void'(exp_due.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = '0;
            shadow[i]  = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_reset", req_ready, 1);

        // corner addresses and data
        do_req(1'b1, 5'h00, 8'hFF);
        do_req(1'b1, 5'h1F, 8'h00);
        do_req(1'b0, 5'h00, 8'h00);
        do_req(1'b0, 5'h1F, 8'h00);
        idle(4);

        // reset asserted during RD_ADDR of a read, held for 2 cycles
        do_req(1'b1, 5'h07, 8'h5A);
        do_req(1'b0, 5'h07, 8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("midop_rst_mem_rd", mem_rd, 0);
        chk("midop_rst_bus", mem_data, probe_val);
        chk("midop_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("midop_ready_after_release", req_ready, 1);
        idle(4);
        do_req(1'b0, 5'h07, 8'h00);
        idle(4);

        // sweep: ascending data to descending addresses, then read back
        for (int i = 0; i <= 30; i++) do_req(1'b1, 5'(31 - i), 8'(i));
        for (int i = 0; i <= 30; i++) do_req(1'b0, 5'(31 - i), 8'h00);
        idle(5);

        // back-to-back with req_valid held: write, read, write to the same address
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'h0A; req_wdata = 8'hA5;
        chk("b2b_ready_wr", req_ready, 1);
        note_accept(1'b1, 5'h0A, 8'hA5);
        for (int k = 0; k < WR_LEN; k++) begin
            @(negedge clk);
            req_wr = 1'b0;
            chk("b2b_ready_wr_busy", req_ready, 0);
        end
        @(negedge clk);
        chk("b2b_ready_rd", req_ready, 1);
        note_accept(1'b0, 5'h0A, 8'hA5);
        repeat (2) begin
            @(negedge clk);
            chk("b2b_ready_rd_busy", req_ready, 0);
        end
        @(negedge clk);
        chk("b2b_ready_after_rd", req_ready, 1);
        chk("b2b_rsp_a5", rsp_rdata, 8'hA5);
        req_wr = 1'b1; req_wdata = 8'h5A;
        note_accept(1'b1, 5'h0A, 8'h5A);
        idle(4);

        // randomized traffic with random gaps
        repeat (250) begin
            automatic logic          wr = 1'($urandom);
            automatic logic [AW-1:0] a  = 5'($urandom);
            automatic logic [DW-1:0] d  = 8'($urandom);
            if (a == 5'd3 && d == 8'h3C) d = 8'h3B;
            do_req(wr, a, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

`ifdef MEM_CTRL_WRCHK_EN
        // clean write keeps the flag low; corrupted write to address 3 sets it sticky until reset
        do_req(1'b1, 5'h04, 8'h11);
        idle(6);
        chk("wrchk_clean", wrchk_err, 0);
        do_req(1'b1, 5'h03, 8'h3C);
        idle(6);
        chk("wrchk_set", wrchk_err, 1);
        do_req(1'b1, 5'h05, 8'h22);
        do_req(1'b0, 5'h03, 8'h00);
        idle(5);
        chk("wrchk_sticky", wrchk_err, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("wrchk_cleared_by_rst", wrchk_err, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        idle(3);
`endif

        chk("rsp_drained", exp_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
